// File: rtl/expmod_arbiter.sv
// Round-robin arbiter sharing one exponent_modulus engine between NUM_REQ requesters.
// Grant is combinational in IDLE; response is registered and held until the owner accepts it.
module expmod_arbiter #(
    parameter int WIDTH          = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    input  logic [NUM_REQ*WIDTH-1:0]   req_value_in,
    input  logic [NUM_REQ*WIDTH-1:0]   req_modulus_in,
    input  logic [NUM_REQ*WIDTH-1:0]   req_exponent_in,
    output logic [NUM_REQ-1:0]         resp_valid_out,
    input  logic [NUM_REQ-1:0]         resp_ready_in,
    output logic [WIDTH-1:0]           resp_data_out,
    output logic                       resp_error_out,
    output logic                       eng_ready_out,
    output logic [WIDTH-1:0]           eng_value_out,
    output logic [WIDTH-1:0]           eng_modulus_out,
    output logic [WIDTH-1:0]           eng_exponent_out,
    input  logic [WIDTH-1:0]           eng_value_in,
    input  logic                       eng_busy_in,
    input  logic                       eng_valid_in,
    output logic                       busy_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, owner, winner;
    logic               any_vld;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               resp_vld;
    logic               start_fire, eng_done, tmo_hit, resp_acc, trivial_mod;
    logic [WIDTH-1:0]   win_val, win_mod, win_exp;

    // Search starts at rr_ptr; iterating downward lets the nearest valid requester win.
    always_comb begin
        winner  = rr_ptr;
        any_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_in[(int'(rr_ptr) + k) % NUM_REQ]) begin
                winner  = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                any_vld = 1'b1;
            end
        end
    end

    assign win_val     = req_value_in[winner*WIDTH +: WIDTH];
    assign win_mod     = req_modulus_in[winner*WIDTH +: WIDTH];
    assign win_exp     = req_exponent_in[winner*WIDTH +: WIDTH];
    assign trivial_mod = (win_mod <= WIDTH'(1));

    assign start_fire = (state == ISSUE) && !eng_busy_in && !eng_valid_in;
    assign eng_done   = (state == WAIT) && eng_valid_in;
    assign tmo_hit    = (state == WAIT) && !eng_valid_in && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_acc   = (state == RESP) && resp_ready_in[owner];

    // Grant is gated by reset so every output reads zero while reset is held.
    assign req_ready_out  = (rst_in && (state == IDLE) && any_vld) ? (NUM_REQ'(1) << winner) : '0;
    assign resp_valid_out = resp_vld ? (NUM_REQ'(1) << owner) : '0;
    assign eng_ready_out  = start_fire;
    assign busy_out       = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_vld) state_nxt = trivial_mod ? RESP : ISSUE;
            ISSUE:   if (start_fire) state_nxt = WAIT;
            WAIT:    if (eng_valid_in || tmo_hit) state_nxt = RESP;
            RESP:    if (resp_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr           <= '0;
            owner            <= '0;
            tmo_cnt          <= '0;
            resp_vld         <= 1'b0;
            resp_data_out    <= '0;
            resp_error_out   <= 1'b0;
            eng_value_out    <= '0;
            eng_modulus_out  <= '0;
            eng_exponent_out <= '0;
        end else begin
            if ((state == IDLE) && any_vld) begin
                eng_value_out    <= win_val;
                eng_modulus_out  <= win_mod;
                eng_exponent_out <= win_exp;
                owner            <= winner;
                if (trivial_mod) begin
                    resp_data_out  <= '0;
                    resp_error_out <= 1'b0;
                    resp_vld       <= 1'b1;
                end
            end

            if (start_fire)          tmo_cnt <= '0;
            else if (state == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;

            // A result arriving on the timeout cycle still wins.
            if (eng_done) begin
                resp_data_out  <= eng_value_in;
                resp_error_out <= 1'b0;
                resp_vld       <= 1'b1;
            end else if (tmo_hit) begin
                resp_data_out  <= '0;
                resp_error_out <= 1'b1;
                resp_vld       <= 1'b1;
            end

            if (resp_acc) begin
                resp_vld <= 1'b0;
                rr_ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_expmod_arbiter.sv
// Randomized bench for expmod_arbiter: behavioural engine plus a requester-level
// round-robin / modular-exponent reference model.
module tb_expmod_arbiter;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int TO = 50;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic [NR-1:0]     req_valid_in;
    logic [NR-1:0]     req_ready_out;
    logic [NR*W-1:0]   req_value_in, req_modulus_in, req_exponent_in;
    logic [NR-1:0]     resp_valid_out;
    logic [NR-1:0]     resp_ready_in;
    logic [W-1:0]      resp_data_out;
    logic              resp_error_out;
    logic              eng_ready_out;
    logic [W-1:0]      eng_value_out, eng_modulus_out, eng_exponent_out;
    logic [W-1:0]      eng_value_in;
    logic              eng_busy_in, eng_valid_in;
    logic              busy_out;

    expmod_arbiter #(.WIDTH(W), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_value_in(req_value_in), .req_modulus_in(req_modulus_in),
        .req_exponent_in(req_exponent_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_data_out(resp_data_out), .resp_error_out(resp_error_out),
        .eng_ready_out(eng_ready_out), .eng_value_out(eng_value_out),
        .eng_modulus_out(eng_modulus_out), .eng_exponent_out(eng_exponent_out),
        .eng_value_in(eng_value_in), .eng_busy_in(eng_busy_in),
        .eng_valid_in(eng_valid_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        longint unsigned r, x, mm;
        if (m <= 1) return '0;
        mm = 64'(m);
        r  = 1;
        x  = 64'(b) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W-1:0];
    endfunction

    // Requester-level model: pending requests and the round-robin pointer.
    int          m_rr = 0;
    bit          pend [NR];
    logic [W-1:0] pv [NR], pm [NR], pe [NR];

    function automatic int model_pick();
        for (int k = 0; k < NR; k++)
            if (pend[(m_rr + k) % NR]) return (m_rr + k) % NR;
        return -1;
    endfunction

    function automatic int lowest_set(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Behavioural engine: busy for eng_lat cycles after a start pulse, then one valid pulse.
    int          eng_lat = 10;
    bit          eng_hang = 0;
    bit          eng_busy_force = 0;
    int          start_count = 0, start_cyc = 0, valid_cyc = 0;
    logic [W-1:0] cap_v, cap_m, cap_e;

    initial begin
        bit started, running;
        int rem;
        started = 0; running = 0; rem = 0;
        eng_busy_in = 0; eng_valid_in = 0; eng_value_in = '0;
        cap_v = '0; cap_m = '0; cap_e = '0;
        forever begin
            @(negedge clk_in);
            started = (eng_ready_out === 1'b1);
            if (started) begin
                start_count++;
                start_cyc = cyc;
                cap_v = eng_value_out; cap_m = eng_modulus_out; cap_e = eng_exponent_out;
            end
            @(posedge clk_in); #1;
            eng_valid_in = 1'b0;
            eng_value_in = $urandom;
            if (started && !eng_hang) begin running = 1; rem = eng_lat; end
            if (running) begin
                rem--;
                if (rem == 0) begin
                    eng_valid_in = 1'b1;
                    eng_value_in = modexp(cap_v, cap_e, cap_m);
                    valid_cyc    = cyc;
                    running      = 0;
                    eng_busy_in  = 1'b0;
                end else begin
                    eng_busy_in = 1'b1;
                end
            end else begin
                eng_busy_in = eng_busy_force;
            end
        end
    end

    task automatic post_req(input int i, input logic [W-1:0] v, input logic [W-1:0] m,
                            input logic [W-1:0] e);
        req_valid_in[i]           = 1'b1;
        req_value_in[i*W +: W]    = v;
        req_modulus_in[i*W +: W]  = m;
        req_exponent_in[i*W +: W] = e;
        pend[i] = 1; pv[i] = v; pm[i] = m; pe[i] = e;
    endtask

    task automatic post_rand(input int i);
        logic [W-1:0] m;
        int sel;
        sel = $urandom_range(0, 7);
        m   = $urandom;
        if (sel == 0)      m = 0;
        else if (sel == 1) m = 1;
        else if (m < 2)    m = 2;
        post_req(i, $urandom, m, $urandom);
    endtask

    // Serves one transaction end-to-end. Entered and left just after a rising edge.
    task automatic serve(input int busy_hold, input bit exp_err, output int got);
        int w, h, sc0, ready_cnt, dly;
        logic [W-1:0] ev, em, ee, ed;
        bit seen;
        got  = -1;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_in);
            if (req_ready_out != 0) seen = 1;
        end
        if (!seen) begin check_eq("grant_seen", 0, 1); return; end
        w   = model_pick();
        got = lowest_set(req_ready_out);
        if (w < 0) begin check_eq("grant_unexpected", 64'(req_ready_out), 0); return; end
        check_eq("grant", 64'(req_ready_out), 64'(1) << w);
        ev = pv[w]; em = pm[w]; ee = pe[w];
        ed = exp_err ? '0 : modexp(ev, ee, em);
        h  = cyc;
        sc0 = start_count;
        @(posedge clk_in); #1;
        req_valid_in[w] = 1'b0;
        pend[w] = 0;
        req_value_in[w*W +: W]    = $urandom;
        req_modulus_in[w*W +: W]  = $urandom;
        req_exponent_in[w*W +: W] = $urandom;
        if (busy_hold > 0) begin
            repeat (busy_hold) @(posedge clk_in);
            @(negedge clk_in);
            check_eq("busy_hold_no_start", 64'(start_count), 64'(sc0));
            check_eq("busy_hold_ready_low", 64'(eng_ready_out), 0);
            @(posedge clk_in); #1;
            eng_busy_force = 0;
        end
        ready_cnt = 0;
        seen = 0;
        for (int c = 0; c < TO + 300 && !seen; c++) begin
            @(negedge clk_in);
            if (req_ready_out != 0) ready_cnt++;
            if (resp_valid_out != 0) seen = 1;
        end
        if (!seen) begin check_eq("resp_seen", 0, 1); return; end
        check_eq("resp_valid", 64'(resp_valid_out), 64'(1) << w);
        check_eq("resp_data", 64'(resp_data_out), 64'(ed));
        check_eq("resp_error", 64'(resp_error_out), 64'(exp_err));
        check_eq("no_grant_while_busy", 64'(ready_cnt), 0);
        check_eq("busy_out", 64'(busy_out), 1);
        if (em <= 1 && !exp_err) begin
            check_eq("bypass_latency", 64'(cyc - h), 1);
            check_eq("bypass_no_start", 64'(start_count), 64'(sc0));
        end else begin
            check_eq("one_start", 64'(start_count), 64'(sc0 + 1));
            check_eq("eng_value", 64'(cap_v), 64'(ev));
            check_eq("eng_modulus", 64'(cap_m), 64'(em));
            check_eq("eng_exponent", 64'(cap_e), 64'(ee));
            if (exp_err) check_eq("timeout_latency", 64'(cyc - start_cyc), 64'(TO + 1));
            else         check_eq("resp_latency", 64'(cyc - valid_cyc), 1);
        end
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) begin
            @(posedge clk_in); #1;
            resp_ready_in = NR'($urandom) & ~(NR'(1) << w);
            @(negedge clk_in);
            check_eq("resp_hold", {27'(resp_valid_out), resp_data_out, resp_error_out},
                     {27'(NR'(1) << w), ed, exp_err});
        end
        @(posedge clk_in); #1;
        resp_ready_in = (NR'(1) << w) | NR'($urandom);
        @(posedge clk_in); #1;
        resp_ready_in = '0;
        m_rr = (w + 1) % NR;
        check_eq("resp_clear", 64'(resp_valid_out), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, bad;
        int order [4];
        int exp_order [4];
        bit seen;
        exp_order = '{0, 2, 0, 1};
        req_valid_in = '0; resp_ready_in = '0;
        req_value_in = '0; req_modulus_in = '0; req_exponent_in = '0;
        for (int i = 0; i < NR; i++) pend[i] = 0;

        post_req(0, $urandom, 32'd1000003, $urandom);
        post_req(2, $urandom, 32'd65537, $urandom);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_eq("rst_req_ready", 64'(req_ready_out), 0);
        check_eq("rst_resp", {resp_valid_out, resp_data_out, resp_error_out}, 0);
        check_eq("rst_eng", {eng_ready_out, busy_out, eng_value_out}, 0);
        check_eq("rst_eng_ops", {eng_modulus_out, eng_exponent_out}, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        serve(0, 0, order[0]);
        serve(0, 0, order[1]);
        post_req(1, 32'd4, 32'd497, 32'd13);
        post_req(0, $urandom, 32'd101, $urandom);
        serve(0, 0, order[2]);
        serve(0, 0, order[3]);
        for (int i = 0; i < 4; i++) check_eq("rr_order", 64'(order[i]), 64'(exp_order[i]));

        post_req(0, 32'd7, 32'd1, 32'd5);
        serve(0, 0, g);
        post_req(3, 32'd9, 32'd0, 32'd4);
        serve(0, 0, g);

        eng_busy_force = 1;
        @(posedge clk_in); #1;
        post_req(1, 32'd5, 32'd13, 32'd3);
        serve(20, 0, g);

        eng_hang = 1;
        post_req(3, 32'd2, 32'd13, 32'd5);
        serve(0, 1, g);
        eng_hang = 0;
        post_req(3, 32'd3, 32'd1000, 32'd7);
        serve(0, 0, g);

        eng_lat = 30;
        post_req(2, $urandom, 32'd1000003, 32'd77);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_in);
            if (req_ready_out != 0) seen = 1;
        end
        check_eq("rst_test_grant", 64'(seen), 1);
        @(posedge clk_in); #1;
        req_valid_in[2] = 1'b0;
        pend[2] = 0;
        repeat (8) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check_eq("midrst_resp", {resp_valid_out, resp_data_out, resp_error_out}, 0);
        check_eq("midrst_ctl", {req_ready_out, eng_ready_out, busy_out}, 0);
        check_eq("midrst_eng_ops", {eng_value_out, eng_modulus_out}, 0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        m_rr = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (resp_valid_out != 0 || busy_out) bad++;
        end
        check_eq("stale_valid_ignored", 64'(bad), 0);
        @(posedge clk_in); #1;
        eng_lat = 5;
        for (int i = 0; i < NR; i++) post_req(i, $urandom, 32'd997, $urandom);
        serve(0, 0, g);
        check_eq("post_reset_grant", 64'(g), 0);
        for (int i = 1; i < NR; i++) serve(0, 0, g);

        for (int it = 0; it < 30; it++) begin
            int mask;
            bit any;
            mask = $urandom_range(0, 15);
            for (int i = 0; i < NR; i++) if (mask[i] && !pend[i]) post_rand(i);
            any = 0;
            for (int i = 0; i < NR; i++) any |= pend[i];
            if (!any) post_rand($urandom_range(0, NR - 1));
            eng_lat = $urandom_range(1, 40);
            serve(0, 0, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
